// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: core-side request/response handshake of the FP issue controller.
interface fpu_issue_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [6:0]  req_funct7;
   logic [2:0]  req_rm;
   logic [4:0]  req_rs1;
   logic [4:0]  req_rs2;
   logic [4:0]  req_rd;
   logic        req_lw;
   logic        req_sw;
   logic [31:0] req_load_data;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_illegal;
   logic        resp_timeout;
   modport master (
      output req_valid, req_funct7, req_rm, req_rs1, req_rs2, req_rd, req_lw, req_sw, req_load_data, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_illegal, resp_timeout
   );
   modport slave (
      input  req_valid, req_funct7, req_rm, req_rs1, req_rs2, req_rd, req_lw, req_sw, req_load_data, resp_ready,
      output req_ready, resp_valid, resp_data, resp_illegal, resp_timeout
   );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: sequences one FP instruction at a time into the FPU and owns the fcsr.
module fpu_issue_ctrl #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic              clk,
   input  logic              n_rst,
   fpu_issue_ctrl_if.slave   core,
   output logic [4:0]        f_rs1,
   output logic [4:0]        f_rs2,
   output logic [4:0]        f_rd,
   output logic [7:0]        f_funct_7,
   output logic [2:0]        frm,
   output logic              f_LW,
   output logic              f_SW,
   output logic [31:0]       dload_ext,
   input  logic              f_ready,
   input  logic [31:0]       FPU_all_out,
   input  logic [4:0]        f_flags,
   output logic              busy,
   input  logic              csr_we,
   input  logic [7:0]        csr_wdata,
   output logic [7:0]        fcsr_out
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       fcsr_q, fcsr_d;
   logic [6:0]       funct7_q, funct7_d;
   logic [2:0]       frm_q, frm_d;
   logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic             lw_q, lw_d, sw_q, sw_d;
   logic [31:0]      ld_q, ld_d;
   logic [31:0]      data_q, data_d;
   logic             illegal_q, illegal_d, timeout_q, timeout_d;
   logic [2:0]       eff;
   logic             drive;
   // Dynamic rounding resolves against the fcsr value seen at accept time.
   assign eff   = (core.req_rm == 3'b111) ? fcsr_q[7:5] : core.req_rm;
   assign drive = (state_q == ISSUE) || (state_q == WAIT);
   assign f_rs1     = drive ? rs1_q : '0;
   assign f_rs2     = drive ? rs2_q : '0;
   assign f_rd      = drive ? rd_q : '0;
   assign f_funct_7 = drive ? {1'b0, funct7_q} : '0;
   assign frm       = drive ? frm_q : '0;
   assign f_LW      = drive & lw_q;
   assign f_SW      = drive & sw_q;
   assign dload_ext = drive ? ld_q : '0;
   assign busy      = state_q != IDLE;
   assign fcsr_out  = fcsr_q;
   assign core.req_ready    = state_q == IDLE;
   assign core.resp_valid   = state_q == RESP;
   assign core.resp_data    = data_q;
   assign core.resp_illegal = illegal_q;
   assign core.resp_timeout = timeout_q;
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      funct7_d  = funct7_q;
      frm_d     = frm_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      rd_d      = rd_q;
      lw_d      = lw_q;
      sw_d      = sw_q;
      ld_d      = ld_q;
      data_d    = data_q;
      illegal_d = illegal_q;
      timeout_d = timeout_q;
      fcsr_d    = csr_we ? csr_wdata : fcsr_q;
      if (state_q == WAIT && f_ready) fcsr_d[4:0] = fcsr_d[4:0] | f_flags;
      case (state_q)
         IDLE: if (core.req_valid) begin
            funct7_d  = core.req_funct7;
            rs1_d     = core.req_rs1;
            rs2_d     = core.req_rs2;
            rd_d      = core.req_rd;
            lw_d      = core.req_lw;
            sw_d      = core.req_sw;
            ld_d      = core.req_load_data;
            frm_d     = eff;
            illegal_d = eff >= 3'b101;
            state_d   = (eff >= 3'b101) ? RESP : ISSUE;
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: if (f_ready) begin
            data_d  = FPU_all_out;
            state_d = RESP;
         end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            data_d    = '0;
            timeout_d = 1'b1;
            state_d   = RESP;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         default: if (core.resp_ready) begin
            data_d    = '0;
            illegal_d = 1'b0;
            timeout_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (n_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         fcsr_q    <= '0;
         funct7_q  <= '0;
         frm_q     <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         lw_q      <= 1'b0;
         sw_q      <= 1'b0;
         ld_q      <= '0;
         data_q    <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         fcsr_q    <= fcsr_d;
         funct7_q  <= funct7_d;
         frm_q     <= frm_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         rd_q      <= rd_d;
         lw_q      <= lw_d;
         sw_q      <= sw_d;
         ld_q      <= ld_d;
         data_q    <= data_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
      end
   end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed checks of the FP issue controller handshake, fcsr and timeout.
module tb_fpu_issue_ctrl;
   logic        clk = 1'b0;
   logic        n_rst;
   logic [4:0]  f_rs1, f_rs2, f_rd;
   logic [7:0]  f_funct_7;
   logic [2:0]  frm;
   logic        f_LW, f_SW;
   logic [31:0] dload_ext;
   logic        f_ready;
   logic [31:0] FPU_all_out;
   logic [4:0]  f_flags;
   logic        busy, csr_we;
   logic [7:0]  csr_wdata, fcsr_out;
   int          checks = 0;
   int          errors = 0;
   int          waits;
   always #5 clk = ~clk;
   fpu_issue_ctrl_if core ();
   fpu_issue_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
      .clk(clk), .n_rst(n_rst), .core(core),
      .f_rs1(f_rs1), .f_rs2(f_rs2), .f_rd(f_rd), .f_funct_7(f_funct_7), .frm(frm),
      .f_LW(f_LW), .f_SW(f_SW), .dload_ext(dload_ext),
      .f_ready(f_ready), .FPU_all_out(FPU_all_out), .f_flags(f_flags),
      .busy(busy), .csr_we(csr_we), .csr_wdata(csr_wdata), .fcsr_out(fcsr_out)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [6:0] f7, input logic [2:0] rm, input logic [4:0] r1, r2, rd,
                       input logic lw, sw, input logic [31:0] ld);
      core.req_funct7 = f7; core.req_rm = rm;
      core.req_rs1 = r1; core.req_rs2 = r2; core.req_rd = rd;
      core.req_lw = lw; core.req_sw = sw; core.req_load_data = ld;
      core.req_valid = 1'b1;
      tick;
      core.req_valid = 1'b0;
   endtask
   task automatic csr(input logic [7:0] v);
      csr_we = 1'b1; csr_wdata = v;
      tick;
      csr_we = 1'b0;
   endtask
   task automatic handshake;
      core.resp_ready = 1'b1;
      tick;
      core.resp_ready = 1'b0;
      chk("hs_valid", core.resp_valid, 0);
      chk("hs_ready", core.req_ready, 1);
   endtask
   // Starting in ISSUE: f_ready is up on the first WAIT cycle, optional csr write on the capture edge.
   task automatic fast_op(input logic [4:0] fl, input logic [31:0] d, input logic we, input logic [7:0] wd);
      f_ready = 1'b1; f_flags = fl; FPU_all_out = d;
      tick;
      chk("fast_wait_valid", core.resp_valid, 0);
      csr_we = we; csr_wdata = wd;
      tick;
      csr_we = 1'b0; f_ready = 1'b0; f_flags = '0; FPU_all_out = '0;
      chk("fast_valid", core.resp_valid, 1);
      chk("fast_data", core.resp_data, d);
   endtask
   initial begin
      n_rst = 1'b1; f_ready = 1'b0; FPU_all_out = '0; f_flags = '0; csr_we = 1'b0; csr_wdata = '0;
      core.req_valid = 1'b0; core.req_funct7 = '0; core.req_rm = '0; core.req_rs1 = '0; core.req_rs2 = '0;
      core.req_rd = '0; core.req_lw = 1'b0; core.req_sw = 1'b0; core.req_load_data = '0; core.resp_ready = 1'b0;
      tick; tick;
      n_rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_ready", core.req_ready, 1);
      chk("rst_fcsr", fcsr_out, 0);
      chk("rst_valid", core.resp_valid, 0);
      chk("rst_frs1", f_rs1, 0);
      chk("rst_data", core.resp_data, 0);
      // basic add, FPU answers after four idle WAIT cycles
      send(7'h00, 3'b000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'h0);
      chk("t1_busy", busy, 1);
      chk("t1_ready", core.req_ready, 0);
      chk("t1_rs1", f_rs1, 1);
      chk("t1_rs2", f_rs2, 2);
      chk("t1_rd", f_rd, 3);
      chk("t1_frm", frm, 0);
      repeat (5) tick;
      chk("t1_wait_valid", core.resp_valid, 0);
      chk("t1_wait_rd", f_rd, 3);
      f_ready = 1'b1; FPU_all_out = 32'h40400000; f_flags = 5'b00001;
      tick;
      f_ready = 1'b0; FPU_all_out = '0; f_flags = '0;
      chk("t1_valid", core.resp_valid, 1);
      chk("t1_data", core.resp_data, 32'h40400000);
      chk("t1_fcsr", fcsr_out, 8'h01);
      chk("t1_resp_rs1", f_rs1, 0);
      chk("t1_illegal", core.resp_illegal, 0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("t1_hold_valid", core.resp_valid, 1);
         chk("t1_hold_data", core.resp_data, 32'h40400000);
      end
      handshake;
      // dynamic rounding from fcsr; frm write mid-op leaves the issued frm alone
      csr(8'h40);
      chk("t2_fcsr", fcsr_out, 8'h40);
      send(7'h10, 3'b111, 5'd5, 5'd6, 5'd7, 1'b0, 1'b1, 32'h0);
      chk("t2_frm_issue", frm, 3'b010);
      chk("t2_funct7", f_funct_7, 8'h10);
      chk("t2_sw", f_SW, 1);
      tick;
      csr(8'h80);
      chk("t2_frm_wait", frm, 3'b010);
      chk("t2_fcsr_busy", fcsr_out, 8'h80);
      f_ready = 1'b1; FPU_all_out = 32'h3f800000;
      tick;
      f_ready = 1'b0;
      chk("t2_data", core.resp_data, 32'h3f800000);
      handshake;
      // dynamic rounding resolving to reserved 101
      csr(8'hA0);
      send(7'h00, 3'b111, 5'd9, 5'd10, 5'd11, 1'b0, 1'b0, 32'h0);
      chk("t2i_valid", core.resp_valid, 1);
      chk("t2i_illegal", core.resp_illegal, 1);
      chk("t2i_rs1", f_rs1, 0);
      chk("t2i_frm", frm, 0);
      chk("t2i_data", core.resp_data, 0);
      handshake;
      chk("t2i_illegal_clr", core.resp_illegal, 0);
      // explicit reserved 110
      send(7'h00, 3'b110, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0, 32'h0);
      chk("t3_illegal", core.resp_illegal, 1);
      tick; tick;
      chk("t3_ready", core.req_ready, 0);
      chk("t3_rd", f_rd, 0);
      handshake;
      // timeout: exactly 64 WAIT cycles, fflags untouched
      csr(8'h03);
      FPU_all_out = 32'h12345678;
      send(7'h00, 3'b000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'h0);
      waits = 0;
      for (int i = 0; i < 200; i++) begin
         tick;
         if (core.resp_valid) break;
         waits++;
      end
      FPU_all_out = '0;
      chk("t4_waits", waits, 64);
      chk("t4_timeout", core.resp_timeout, 1);
      chk("t4_data", core.resp_data, 0);
      chk("t4_fcsr", fcsr_out, 8'h03);
      handshake;
      chk("t4_timeout_clr", core.resp_timeout, 0);
      // sticky flags, 3-cycle latency, load lines, csr write on capture edge
      csr(8'h00);
      send(7'h00, 3'b000, 5'd4, 5'd0, 5'd8, 1'b1, 1'b0, 32'hdeadbeef);
      chk("t5_lw", f_LW, 1);
      chk("t5_dload", dload_ext, 32'hdeadbeef);
      fast_op(5'b10000, 32'h1, 1'b0, 8'h00);
      chk("t5_fcsr1", fcsr_out, 8'h10);
      chk("t5_dload_resp", dload_ext, 0);
      handshake;
      send(7'h00, 3'b001, 5'd4, 5'd0, 5'd8, 1'b0, 1'b0, 32'h0);
      fast_op(5'b00100, 32'h2, 1'b0, 8'h00);
      chk("t5_fcsr2", fcsr_out, 8'h14);
      handshake;
      send(7'h00, 3'b001, 5'd4, 5'd0, 5'd8, 1'b0, 1'b0, 32'h0);
      fast_op(5'b00100, 32'h3, 1'b1, 8'h00);
      chk("t5_fcsr3", fcsr_out, 8'h04);
      handshake;
      // reset while in WAIT
      send(7'h00, 3'b000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'h0);
      tick;
      n_rst = 1'b1;
      tick;
      n_rst = 1'b0;
      chk("t6_busy", busy, 0);
      chk("t6_ready", core.req_ready, 1);
      chk("t6_fcsr", fcsr_out, 0);
      chk("t6_valid", core.resp_valid, 0);
      f_ready = 1'b1; FPU_all_out = 32'hcafef00d; f_flags = 5'b11111;
      tick; tick;
      f_ready = 1'b0;
      chk("t6_late_valid", core.resp_valid, 0);
      chk("t6_late_busy", busy, 0);
      chk("t6_late_fcsr", fcsr_out, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Sequencer directly upstream of the FPU top (FPU_all).
- Accepts one decoded FP instruction at a time from the core over a valid/ready handshake and resolves its rounding mode against the fcsr.
- Drives the FPU operand, rd and control lines, waits for f_ready, then returns the result and exception status to the core.
- Owns the fcsr: frm plus sticky fflags.

Parameters:
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before the operation is abandoned.
- CNT_W, 7: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock.
- n_rst  in  1  synchronous reset; ACTIVE-HIGH (n_rst=1 resets on the clk edge).
- req_valid  in  1  core presents an FP instruction.
- req_ready  out  1  controller can accept an instruction.
- req_funct7  in  7  operation select.
- req_rm  in  3  instruction rounding-mode field (3'b111 = dynamic).
- req_rs1, req_rs2, req_rd  in  5 each  FP register indices.
- req_lw, req_sw  in  1 each  FP load / FP store; mutually exclusive.
- req_load_data  in  32  memory word for FP load.
- f_rs1, f_rs2, f_rd  out  5 each  to FPU.
- f_funct_7  out  8  {1'b0, latched funct7}.
- frm  out  3  resolved rounding mode.
- f_LW, f_SW  out  1 each  to FPU.
- dload_ext  out  32  latched load data.
- f_ready  in  1  FPU operation complete.
- FPU_all_out  in  32  FPU result / store data.
- f_flags  in  5  NV,DZ,OF,UF,NX from FPU.
- resp_valid  out  1  response available.
- resp_ready  in  1  core consumes response.
- resp_data  out  32  captured FPU_all_out.
- resp_illegal  out  1  rounding mode invalid; no FPU issue.
- resp_timeout  out  1  FPU did not answer.
- busy  out  1  state != IDLE.
- csr_we  in  1  write fcsr.
- csr_wdata  in  8  {frm[2:0], fflags[4:0]}.
- fcsr_out  out  8  {frm, fflags}.

Behaviour:
- Reset (n_rst=1 at a clk edge): state=IDLE; fcsr=8'h00; counter=0. All latched fields, f_* outputs, resp_* outputs and busy are 0. req_ready=1 from the cycle after reset.
- Reset mid-operation aborts immediately: no response is produced, and fflags clear.

State machine (IDLE, ISSUE, WAIT, RESP):
- IDLE:
  - req_ready=1.
  - Accept on req_valid & req_ready: latch all req_* fields.
  - Resolve rm: eff = (req_rm==3'b111) ? fcsr.frm : req_rm.
  - If eff ∈ {3'b101, 3'b110, 3'b111}: resp_illegal=1, go to RESP; no FPU lines are driven.
  - Otherwise go to ISSUE.
- ISSUE:
  - Exactly one cycle.
  - f_rs1/f_rs2/f_rd/f_funct_7/frm/f_LW/f_SW/dload_ext driven from the latches; they stay stable through WAIT.
  - counter=0. Go to WAIT.
- WAIT:
  - Each cycle, if f_ready=1: capture resp_data=FPU_all_out, OR f_flags into fflags, go to RESP.
  - Else counter+1. When counter==TIMEOUT_CYCLES-1 without f_ready: resp_timeout=1, resp_data=0, fflags unchanged, go to RESP.
  - f_ready arriving in the same cycle as the timeout: f_ready wins.
  - f_ready outside WAIT is ignored.
- RESP:
  - resp_valid=1, with resp_* held stable until resp_ready=1.
  - On the resp_ready handshake cycle go to IDLE; resp_illegal, resp_timeout and the FPU drive lines clear to 0.
  - resp_ready=1 held continuously allows back-to-back instructions. A new request can be accepted at earliest the cycle after the handshake, giving a minimum latency of 3 cycles plus the FPU time.
- f_* drive lines are 0 in IDLE and RESP.
- Minimum request-to-resp_valid latency:
  - 1 cycle for an illegal rounding mode.
  - 3 cycles when f_ready is already 1 on the first WAIT cycle.

fcsr:
- csr_we writes fcsr=csr_wdata in any state.
- When csr_we coincides with a WAIT flag capture: fflags = csr_wdata[4:0] | f_flags; frm = csr_wdata[7:5].
- A frm write during a busy operation does not affect the already-resolved frm output.
- fflags are sticky: cleared only by reset or csr_we.

Test Plan:
- After reset, send funct7=7'h00, rm=3'b000, rs1=1, rs2=2, rd=3. FPU asserts f_ready after 4 WAIT cycles with FPU_all_out=32'h40400000, f_flags=5'b00001 -> resp_valid with resp_data=32'h40400000 and fcsr_out=8'h01. Outputs are stable while resp_ready is held 0 for 3 cycles.
- Program csr_wdata=8'h40 (frm=3'b010), then send rm=3'b111 -> frm output = 3'b010 during ISSUE/WAIT. Repeat with fcsr frm=3'b101 -> resp_illegal=1 one cycle after accept; f_rs1 and the other f_* lines never leave 0.
- Send req_rm=3'b110 -> resp_illegal=1; req_ready=0 until the resp handshake.
- FPU never asserts f_ready with TIMEOUT_CYCLES=64 -> resp_valid with resp_timeout=1 and resp_data=0, 64 WAIT cycles after ISSUE; fflags unchanged.
- Two ops returning f_flags 5'b10000 then 5'b00100 -> fcsr_out[4:0]=5'b10100. csr_we with 8'h00 in the same cycle as the second capture -> 5'b00100.
- Assert n_rst=1 during WAIT -> the next cycle shows busy=0, req_ready=1, fcsr_out=0, resp_valid=0. A late f_ready produces no response.
